// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
// Stall/flush sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Each cycle exactly one action is chosen, highest priority first:
//   1. memory hold    - MEM access not yet acknowledged; freeze everything and
//                       push a bubble into WB
//   2. redirect       - taken branch/jump resolved in MEM; squash IF/ID, ID/EX
//                       and EX/MEM
//   3. load-use stall - ID reads the register an EX load is about to write;
//                       hold PC and IF/ID and insert one bubble into ID/EX
//   4. normal flow    - everything advances
// A MEM access that stays unacknowledged for MAX_WAIT consecutive cycles
// locks the unit in TIMEOUT until reset.
//
// Handshake: this block has no valid/ready ports. dmem_ready acts as the
// acknowledge for an outstanding MEM access (mem_req). The access completes
// in the first cycle where dmem_ready is high, and the pipeline advances in
// that same cycle.
module pipeline_hazard_unit #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic [1:0]       ex_memtoreg,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             mem_redirect,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_en,
    output logic             mem_wb_flush,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    // Registered state
    state_t           r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Decoded conditions
    logic       w_in_run;
    logic       w_in_wait;
    logic       w_in_timeout;
    logic       w_lu;
    logic       w_hold;
    logic       w_redirect_ok;
    logic [7:0] w_wait_next;
    logic       w_timeout_hit;

    // Combinational pipeline-register controls
    logic w_pc_en;
    logic w_if_id_en;
    logic w_if_id_flush;
    logic w_id_ex_en;
    logic w_id_ex_flush;
    logic w_ex_mem_en;
    logic w_ex_mem_flush;
    logic w_mem_wb_en;
    logic w_mem_wb_flush;

    assign w_in_run     = (r_state == ST_RUN);
    assign w_in_wait    = (r_state == ST_WAIT);
    assign w_in_timeout = (r_state == ST_TIMEOUT);

    // Load in EX writing a non-zero register that the ID instruction reads.
    // x0 is hardwired to zero, so it never creates a dependency.
    assign w_lu = ex_regwrite && (ex_memtoreg == 2'd1) && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

    // In WAIT the access is already outstanding, so mem_req is not re-checked.
    assign w_hold = (w_in_run && mem_req && !dmem_ready) ||
                    (w_in_wait && !dmem_ready);

    // A redirect is accepted only when nothing of higher priority blocks it;
    // this includes the WAIT release cycle.
    assign w_redirect_ok = !w_in_timeout && !w_hold && mem_redirect;

    assign w_wait_next   = r_wait_cnt + 8'd1;
    assign w_timeout_hit = w_hold && (w_wait_next == LP_MAX_WAIT);

    // Priority decode of the enable/flush controls; reset forces bubbles everywhere
    always_comb begin
        w_pc_en        = 1'b1;
        w_if_id_en     = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_en     = 1'b1;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_en    = 1'b1;
        w_ex_mem_flush = 1'b0;
        w_mem_wb_en    = 1'b1;
        w_mem_wb_flush = 1'b0;
        if (!rst_n) begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_en     = 1'b0;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_en    = 1'b0;
            w_ex_mem_flush = 1'b1;
            w_mem_wb_en    = 1'b0;
            w_mem_wb_flush = 1'b1;
        end else if (w_in_timeout) begin
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_id_ex_en  = 1'b0;
            w_ex_mem_en = 1'b0;
            w_mem_wb_en = 1'b0;
        end else if (w_hold) begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_en     = 1'b0;
            w_ex_mem_en    = 1'b0;
            w_mem_wb_en    = 1'b0;
            w_mem_wb_flush = 1'b1;
        end else if (mem_redirect) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
        end else if (w_lu) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
        end
    end

    // FSM: RUN/WAIT track the outstanding MEM access, TIMEOUT is terminal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN, ST_WAIT: begin
                    if (w_hold) begin
                        r_wait_cnt <= w_wait_next;
                        if (w_timeout_hit) begin
                            r_state       <= ST_TIMEOUT;
                            r_timeout_err <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 8'd0;
                    end
                end
                ST_TIMEOUT: begin
                    r_state       <= ST_TIMEOUT;
                    r_timeout_err <= 1'b1;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Saturating performance counters: stalled-PC cycles and accepted redirects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redirect_ok && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_en        = w_pc_en;
    assign if_id_en     = w_if_id_en;
    assign if_id_flush  = w_if_id_flush;
    assign id_ex_en     = w_id_ex_en;
    assign id_ex_flush  = w_id_ex_flush;
    assign ex_mem_en    = w_ex_mem_en;
    assign ex_mem_flush = w_ex_mem_flush;
    assign mem_wb_en    = w_mem_wb_en;
    assign mem_wb_flush = w_mem_wb_flush;
    assign timeout_err  = r_timeout_err;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Testbench for pipeline_hazard_unit (MAX_WAIT=4, CNT_W=4 so timeout and
// counter saturation are reachable in a short run).
module tb_pipeline_hazard_unit;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    // Control word: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //                ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush}
    localparam logic [8:0] C_NORM  = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] C_LU    = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] C_REDIR = 9'b1_1_1_1_1_1_1_1_0;
    localparam logic [8:0] C_HOLD  = 9'b0_0_0_0_0_0_0_0_1;
    localparam logic [8:0] C_TMO   = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] C_RST   = 9'b0_0_1_0_1_0_1_0_1;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_regwrite = 1'b0;
    logic [1:0] ex_memtoreg = '0;
    logic mem_req = 1'b0, dmem_ready = 1'b1, mem_redirect = 1'b0;

    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, timeout_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0] ctrl;

    assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                   ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush};

    pipeline_hazard_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .mem_req(mem_req), .dmem_ready(dmem_ready), .mem_redirect(mem_redirect),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
        .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
        .timeout_err(timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Tracks: number of consecutive unacknowledged MEM cycles, whether the
    // unit has timed out, and plain integer counts of stalls and redirects.
    int m_wait_n = 0;
    bit m_to = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    function automatic logic [8:0] model_ctrl();
        logic lu;
        lu = ex_regwrite && (ex_memtoreg == 2'd1) && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        if (m_to) return C_TMO;
        if (!dmem_ready && (mem_req || m_wait_n > 0)) return C_HOLD;
        if (mem_redirect) return C_REDIR;
        if (lu) return C_LU;
        return C_NORM;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                         input logic a_u1, input logic a_u2, input logic [4:0] a_rd,
                         input logic a_rw, input logic [1:0] a_mtr,
                         input logic a_mreq, input logic a_rdy, input logic a_redir);
        @(negedge clk);
        id_rs1 = a_rs1; id_rs2 = a_rs2; id_use_rs1 = a_u1; id_use_rs2 = a_u2;
        ex_rd = a_rd; ex_regwrite = a_rw; ex_memtoreg = a_mtr;
        mem_req = a_mreq; dmem_ready = a_rdy; mem_redirect = a_redir;
        #1;
    endtask

    // Advance one clock edge and let the model follow it.
    task automatic tick();
        logic [8:0] e;
        e = model_ctrl();
        @(posedge clk);
        if (!e[8] && m_stall < CNT_MAX) m_stall++;
        if (e == C_REDIR && m_flush < CNT_MAX) m_flush++;
        if (e == C_HOLD) begin
            m_wait_n++;
            if (m_wait_n == MAX_WAIT) m_to = 1'b1;
        end else begin
            m_wait_n = 0;
        end
    endtask

    task automatic check_all(input string nm, input logic [8:0] ec,
                             input int es, input int ef, input logic ee);
        n_vec++;
        if (ctrl !== ec || stall_cnt !== CNT_W'(es) || flush_cnt !== CNT_W'(ef) ||
            timeout_err !== ee) begin
            n_err++;
            $display("FAIL %s: got ctrl=%b stall=%0d flush=%0d err=%b, want ctrl=%b stall=%0d flush=%0d err=%b",
                     nm, ctrl, stall_cnt, flush_cnt, timeout_err, ec, es, ef, ee);
        end
    endtask

    task automatic check_ctrl(input string nm, input logic [8:0] ec);
        n_vec++;
        if (ctrl !== ec) begin
            n_err++;
            $display("FAIL %s: got ctrl=%b, want ctrl=%b", nm, ctrl, ec);
        end
    endtask

    task automatic step(input string nm, input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                        input logic a_u1, input logic a_u2, input logic [4:0] a_rd,
                        input logic a_rw, input logic [1:0] a_mtr,
                        input logic a_mreq, input logic a_rdy, input logic a_redir,
                        input logic [8:0] ec, input int es, input int ef, input logic ee);
        drive(a_rs1, a_rs2, a_u1, a_u2, a_rd, a_rw, a_mtr, a_mreq, a_rdy, a_redir);
        check_all(nm, ec, es, ef, ee);
        tick();
    endtask

    // Asynchronous reset pulse, asserted away from the clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_regwrite = 1'b0; ex_memtoreg = '0;
        mem_req = 1'b0; dmem_ready = 1'b1; mem_redirect = 1'b0;
        #1;
        check_all("reset", C_RST, 0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_wait_n = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] mtr;
        logic       mreq, rdy, redir;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[13];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        tbl[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0, C_NORM};
        tbl[1]  = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 2'd1, 1'b0, 1'b1, 1'b0, C_LU};
        tbl[2]  = '{5'd0,  5'd7,  1'b0, 1'b1, 5'd7,  1'b1, 2'd1, 1'b0, 1'b1, 1'b0, C_LU};
        tbl[3]  = '{5'd5,  5'd0,  1'b0, 1'b0, 5'd5,  1'b1, 2'd1, 1'b0, 1'b1, 1'b0, C_NORM};
        tbl[4]  = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 2'd1, 1'b0, 1'b1, 1'b0, C_NORM};
        tbl[5]  = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 2'd0, 1'b0, 1'b1, 1'b0, C_NORM};
        tbl[6]  = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 2'd2, 1'b0, 1'b1, 1'b0, C_NORM};
        tbl[7]  = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b0, 2'd1, 1'b0, 1'b1, 1'b0, C_NORM};
        tbl[8]  = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 2'd1, 1'b0, 1'b1, 1'b1, C_REDIR};
        tbl[9]  = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 2'd1, 1'b1, 1'b1, 1'b0, C_LU};
        tbl[10] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 1'b1, 1'b1, 1'b1, C_REDIR};
        tbl[11] = '{5'd0,  5'd31, 1'b0, 1'b1, 5'd31, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, C_LU};
        tbl[12] = '{5'd4,  5'd6,  1'b1, 1'b1, 5'd5,  1'b1, 2'd1, 1'b0, 1'b1, 1'b0, C_NORM};

        // Reset values
        do_reset();

        // Single-cycle decode vectors (no MEM hold, so each is independent)
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
                  tbl[i].rw, tbl[i].mtr, tbl[i].mreq, tbl[i].rdy, tbl[i].redir);
            check_ctrl($sformatf("table[%0d]", i), tbl[i].exp);
            tick();
        end

        // lw x5 ; add x?,x5 -> exactly one bubble, then flow resumes
        do_reset();
        step("lu_stall",   5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, C_LU,   0, 0, 1'b0);
        step("lu_release", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, C_NORM, 1, 0, 1'b0);
        step("lu_x0",      5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, C_NORM, 1, 0, 1'b0);
        step("alu_rd5",    5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, C_NORM, 1, 0, 1'b0);
        // Redirect wins over a simultaneous load-use
        step("redir_lu",   5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, C_REDIR, 1, 0, 1'b0);
        step("redir_after",5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, C_NORM, 1, 1, 1'b0);

        // MEM wait of 3 cycles, then acknowledge
        do_reset();
        for (int i = 0; i < 3; i++)
            step("mem_hold", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, C_HOLD, i, 0, 1'b0);
        step("mem_ack",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, C_NORM, 3, 0, 1'b0);
        step("mem_after", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, C_NORM, 3, 0, 1'b0);

        // Redirect held during a 2-cycle wait is taken on the release cycle
        do_reset();
        for (int i = 0; i < 2; i++)
            step("redir_hold", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, C_HOLD, i, 0, 1'b0);
        step("redir_rel",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, C_REDIR, 2, 0, 1'b0);
        step("redir_done", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, C_NORM, 2, 1, 1'b0);

        // Timeout after MAX_WAIT unacknowledged cycles; sticky until reset
        do_reset();
        for (int i = 0; i < MAX_WAIT; i++)
            step("to_hold", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, C_HOLD, i, 0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("to_sticky", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1,
                 C_TMO, MAX_WAIT + i, 0, 1'b1);
        do_reset();   // async reset mid-TIMEOUT
        step("to_recover", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, C_NORM, 0, 0, 1'b0);

        // Counter saturation at all-ones
        do_reset();
        for (int i = 0; i < CNT_MAX + 2; i++)
            step("sat_flush", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1,
                 C_REDIR, 0, (i < CNT_MAX) ? i : CNT_MAX, 1'b0);
        for (int i = 0; i < CNT_MAX + 2; i++)
            step("sat_stall", 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0,
                 C_LU, (i < CNT_MAX) ? i : CNT_MAX, CNT_MAX, 1'b0);
        step("sat_final", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0,
             C_NORM, CNT_MAX, CNT_MAX, 1'b0);

        // Randomized stimulus against the reference model
        for (int blk = 0; blk < 8; blk++) begin
            do_reset();
            for (int i = 0; i < 50; i++) begin
                drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 5) == 0));
                check_all("random", model_ctrl(), m_stall, m_flush, m_to);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
